hex_word_ascii_tx: RTL

Serialises a binary word into uppercase ASCII hex characters, most-significant nibble first, optionally followed by CR LF. It is the transmit-side counterpart of the ASCII-hex character decoder and feeds the debug/console byte stream, for example a UART TX. Every digit it emits decodes back to the original nibble with the not-hex flag clear. Words are accepted on a valid/ready handshake and characters are produced on a second valid/ready handshake.

---
 rtl/hex_word_ascii_tx_pkg.sv | 24 ++
 rtl/hex_word_ascii_tx_nibble_to_ascii.sv | 24 ++
 rtl/hex_word_ascii_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hex_word_ascii_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_word_ascii_tx_pkg
// Description : Shared constants and state encoding for the ASCII hex word
//               transmitter. The ASCII offsets are shared with the
//               ASCII-hex character decoder on the receive side.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_word_ascii_tx_pkg;

    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;  // '0' - 0
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;  // 'A' - 10

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        CR    = 2'd2,
        LF    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_word_ascii_tx_nibble_to_ascii.sv
`default_nettype none
// ============================================================================
// Module      : hex_word_ascii_tx_nibble_to_ascii
// Description : Maps one 4-bit nibble to its uppercase ASCII hex digit.
//               0..9 -> 0x30..0x39, 10..15 -> 0x41..0x46.
// Ports       : i_nibble  in  4  nibble value
//               o_ascii   out 8  ASCII character
// Revision    : 1.0 - initial release
// ============================================================================
module hex_word_ascii_tx_nibble_to_ascii (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);
    import hex_word_ascii_tx_pkg::*;

    logic [7:0] w_nibble_ext;

    assign w_nibble_ext = {4'h0, i_nibble};
    // Largest result is 0x0F + 0x37 = 0x46, so the 8-bit add cannot overflow.
    assign o_ascii = (i_nibble < 4'd10) ? (w_nibble_ext + ASCII_DIGIT_OFS)
                                        : (w_nibble_ext + ASCII_ALPHA_OFS);

endmodule
`default_nettype wire

// File: rtl/hex_word_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module      : hex_word_ascii_tx
// Description : Serialises a binary word into uppercase ASCII hex characters,
//               most-significant nibble first, optionally followed by CR LF.
//               Words arrive on a valid/ready handshake; characters leave on
//               a second valid/ready handshake, one per cycle at full rate.
// Ports       : clk         in  1                system clock
//               rst         in  1                async active-high reset
//               word_in     in  4*WORD_NIBBLES   word to print
//               word_valid  in  1                word_in valid
//               word_ready  out 1                accepting words (IDLE only)
//               char_out    out 8                registered ASCII character
//               char_valid  out 1                char_out valid
//               char_ready  in  1                downstream takes char_out
//               busy        out 1                not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module hex_word_ascii_tx #(
    parameter int WORD_NIBBLES = 8,
    parameter int EMIT_NEWLINE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*WORD_NIBBLES-1:0] word_in,
    input  logic                      word_valid,
    output logic                      word_ready,
    output logic [7:0]                char_out,
    output logic                      char_valid,
    input  logic                      char_ready,
    output logic                      busy
);
    import hex_word_ascii_tx_pkg::*;

    localparam int c_word_w = 4 * WORD_NIBBLES;
    localparam int c_cnt_w  = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WORD_NIBBLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t                r_state, w_state_nxt;
    logic [c_word_w-1:0]   r_shift, w_shift_nxt;
    logic [c_cnt_w-1:0]    r_cnt,   w_cnt_nxt;
    logic [7:0]            r_char,  w_char_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  w_char_hs;
    logic [7:0]            w_digit_ascii;

    assign w_char_hs = r_valid && char_ready;

    // The digit converter looks at the top nibble of the shift register's
    // next value, so the same instance serves both the word-accept load and
    // the shift-and-load that advances to the following digit.
    hex_word_ascii_tx_nibble_to_ascii u_nibble_to_ascii (
        .i_nibble (w_shift_nxt[c_word_w-1 -: 4]),
        .o_ascii  (w_digit_ascii)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_char  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_char  <= w_char_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_char_nxt  = r_char;
        w_valid_nxt = r_valid;

        case (r_state)
            IDLE: begin
                // word_ready is implied by being in IDLE.
                if (word_valid) begin
                    w_shift_nxt = word_in;
                    w_char_nxt  = w_digit_ascii;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = c_cnt_init;
                    w_state_nxt = DIGIT;
                end
            end
            DIGIT: begin
                if (w_char_hs) begin
                    w_shift_nxt = r_shift << 4;
                    if (r_cnt != '0) begin
                        w_char_nxt = w_digit_ascii;
                        w_cnt_nxt  = r_cnt - c_cnt_one;
                    end else if (EMIT_NEWLINE != 0) begin
                        w_char_nxt  = ASCII_CR;
                        w_state_nxt = CR;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            CR: begin
                if (w_char_hs) begin
                    w_char_nxt  = ASCII_LF;
                    w_state_nxt = LF;
                end
            end
            LF: begin
                if (w_char_hs) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign word_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign char_out   = r_char;
    assign char_valid = r_valid;

endmodule
`default_nettype wire
